// File: rtl/play_pkg.sv
// Shared playback definitions: pacer state encoding and the speed-factor encoding
// that the pacer and the interpolator both use.
package play_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    localparam int MAX_SPEED = 8;

    // Speed 0 and anything above MAX_SPEED collapse to 1x.
    function automatic logic [3:0] sanitize_speed(input logic [3:0] speed);
        if (speed == 4'd0 || speed > 4'(MAX_SPEED)) begin
            return 4'd1;
        end
        return speed;
    endfunction

endpackage

// File: rtl/play_pacer.sv
// Playback pacer: reads SRAM samples at the DAC rate, emits one-cycle valid pulses.
// Latency: accepted sample request at t -> o_valid/o_data at t+2; pause/stop drop requests.
module play_pacer
    import play_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_fast,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_sample_req,
    input  logic [15:0]       i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_valid,
    output logic [15:0]       o_data,
    output logic              o_pause,
    output logic              o_busy,
    output logic              o_done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        slot_q, slot_d;
    logic [3:0]        step_q, step_d;
    logic [3:0]        period_q, period_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    logic [3:0]        speed_n;
    logic [ADDR_W:0]   next_addr;
    logic              past_end;

    assign speed_n   = sanitize_speed(i_speed);
    // One extra bit so a carry out of the address range also counts as past the end.
    assign next_addr = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, step_q};
    assign past_end  = next_addr > {1'b0, i_end_addr};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            slot_q   <= '0;
            step_q   <= 4'd1;
            period_q <= 4'd1;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            slot_q   <= slot_d;
            step_q   <= step_d;
            period_q <= period_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        slot_d   = slot_q;
        step_d   = step_q;
        period_d = period_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_WAIT;
                    addr_d  = '0;
                    slot_d  = '0;
                end
            end

            ST_WAIT: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    slot_d  = '0;
                end else if (!i_pause && i_sample_req) begin
                    if (slot_q == 4'd0) begin
                        // Speed mode is sampled here so mid-playback changes apply per fetch.
                        step_d   = i_fast ? speed_n : 4'd1;
                        period_d = i_fast ? 4'd1 : speed_n;
                        state_d  = ST_FETCH;
                    end else begin
                        slot_d = slot_q - 4'd1;
                    end
                end
            end

            ST_FETCH: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    slot_d  = '0;
                end else begin
                    data_d  = i_sram_data;
                    valid_d = 1'b1;
                    slot_d  = period_q - 4'd1;
                    if (past_end) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        addr_d  = '0;
                    end else begin
                        addr_d  = next_addr[ADDR_W-1:0];
                        state_d = ST_WAIT;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
                slot_d  = '0;
            end
        endcase
    end

    assign o_sram_addr = addr_q;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_pause     = i_pause && (state_q != ST_IDLE);

endmodule

// File: tb/tb_play_pacer.sv
// Bench for play_pacer: per-cycle comparison against a playback model plus directed scenarios.
module tb_play_pacer;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, fast = 1'b0, req = 1'b0;
    logic [3:0]    speed = 4'd1;
    logic [AW-1:0] end_addr = '0;
    logic [15:0]   sram_q = '0;
    logic [AW-1:0] sram_addr;
    logic          valid, pause_o, busy, done;
    logic [15:0]   data;

    always #5 clk = ~clk;

    play_pacer #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_pause(pause),
        .i_fast(fast), .i_speed(speed), .i_end_addr(end_addr), .i_sample_req(req),
        .i_sram_data(sram_q), .o_sram_addr(sram_addr), .o_valid(valid), .o_data(data),
        .o_pause(pause_o), .o_busy(busy), .o_done(done)
    );

    // Synchronous SRAM whose word k holds 16'h1000 + k.
    always @(posedge clk) sram_q <= 16'h1000 + 16'(sram_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Playback model: position in the recording, requests still to skip, pending fetch.
    bit          m_busy, m_fetch, m_valid, m_done;
    int          m_pos, m_skip, m_step, m_period;
    logic [15:0] m_data;

    function automatic int legal_speed(input logic [3:0] s);
        return (s == 0 || s > 8) ? 1 : int'(s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0;
            m_pos = 0; m_skip = 0; m_step = 1; m_period = 1; m_data = 16'h0;
        end else begin
            m_valid = 0;
            m_done  = 0;
            if (m_busy && stop) begin
                m_busy = 0; m_fetch = 0; m_pos = 0; m_skip = 0;
            end else if (m_fetch) begin
                m_fetch = 0;
                m_valid = 1;
                m_data  = 16'h1000 + 16'(m_pos);
                m_skip  = m_period - 1;
                if (m_pos + m_step > int'(end_addr)) begin
                    m_done = 1; m_busy = 0; m_pos = 0;
                end else begin
                    m_pos += m_step;
                end
            end else if (m_busy) begin
                if (!pause && req) begin
                    if (m_skip == 0) begin
                        m_step   = fast ? legal_speed(speed) : 1;
                        m_period = fast ? 1 : legal_speed(speed);
                        m_fetch  = 1;
                    end else begin
                        m_skip--;
                    end
                end
            end else if (start) begin
                m_busy = 1; m_pos = 0; m_skip = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(valid), 32'(m_valid));
            chk("done", 32'(done), 32'(m_done));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("addr", 32'(sram_addr), 32'(m_pos));
            chk("data", 32'(data), 32'(m_data));
            chk("pause", 32'(pause_o), 32'(pause && m_busy));
        end
    end

    // Record every delivered sample for the scenario-level literal checks.
    logic [15:0] obs[$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && valid) obs.push_back(data);
        if (rst_n && done) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_req();
        req = 1'b1; tick(1); req = 1'b0;
    endtask

    task automatic play(input string name, input bit f, input logic [3:0] spd, input int last,
                        input int nreq, input logic [15:0] exp[$]);
        int b_obs = obs.size();
        int b_done = done_cnt;
        fast = f; speed = spd; end_addr = AW'(last);
        pulse_start();
        tick(2);
        repeat (nreq) begin
            pulse_req();
            tick(6);
        end
        chk({name, " count"}, 32'(obs.size() - b_obs), 32'(exp.size()));
        for (int i = 0; i < exp.size() && b_obs + i < obs.size(); i++)
            chk({name, " sample"}, 32'(obs[b_obs + i]), 32'(exp[i]));
        chk({name, " done"}, 32'(done_cnt - b_done), 32'd1);
        chk({name, " idle"}, 32'(busy), 32'd0);
    endtask

    logic [15:0] exp_q[$];
    int b_obs, b_done;

    initial begin
        tick(2);
        chk("rst addr", 32'(sram_addr), 32'd0);
        chk("rst data", 32'(data), 32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pause", 32'(pause_o), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Normal 1x: four samples, done two cycles after the fourth request.
        b_obs = obs.size(); b_done = done_cnt;
        fast = 0; speed = 4'd1; end_addr = AW'(3);
        pulse_start();
        chk("start busy", 32'(busy), 32'd1);
        repeat (3) begin pulse_req(); tick(9); end
        pulse_req();
        chk("fetch addr", 32'(sram_addr), 32'd3);
        tick(1);
        chk("last valid", 32'(valid), 32'd1);
        chk("last data", 32'(data), 32'h1003);
        chk("last done", 32'(done), 32'd1);
        tick(1);
        chk("after busy", 32'(busy), 32'd0);
        chk("after done", 32'(done), 32'd0);
        chk("normal count", 32'(obs.size() - b_obs), 32'd4);
        for (int i = 0; i < 4 && b_obs + i < obs.size(); i++)
            chk("normal sample", 32'(obs[b_obs + i]), 32'h1000 + 32'(i));
        chk("normal done", 32'(done_cnt - b_done), 32'd1);
        tick(3);

        exp_q = '{16'h1000, 16'h1001};
        play("slow4", 1'b0, 4'd4, 1, 8, exp_q);
        exp_q = '{16'h1000, 16'h1003, 16'h1006};
        play("fast3", 1'b1, 4'd3, 7, 4, exp_q);
        exp_q = '{16'h1000};
        play("end0", 1'b0, 4'd1, 0, 2, exp_q);
        exp_q = '{16'h1000, 16'h1001, 16'h1002};
        play("speed0", 1'b0, 4'd0, 2, 3, exp_q);
        play("speed12", 1'b0, 4'd12, 2, 3, exp_q);
        play("fast12", 1'b1, 4'd12, 2, 3, exp_q);

        // Pause after two samples for five requests.
        b_obs = obs.size();
        fast = 0; speed = 4'd1; end_addr = AW'(7);
        pulse_start(); tick(2);
        repeat (2) begin pulse_req(); tick(6); end
        pause = 1'b1; tick(1);
        chk("paused flag", 32'(pause_o), 32'd1);
        repeat (5) begin pulse_req(); tick(6); end
        chk("paused count", 32'(obs.size() - b_obs), 32'd2);
        chk("paused addr", 32'(sram_addr), 32'd2);
        pause = 1'b0;
        pulse_req(); tick(6);
        chk("resume count", 32'(obs.size() - b_obs), 32'd3);
        if (obs.size() > 0) chk("resume sample", 32'(obs[obs.size() - 1]), 32'h1002);
        stop = 1'b1; tick(1); stop = 1'b0;
        chk("stop idle", 32'(busy), 32'd0);
        tick(2);

        // Stop coincident with a request, then replay from the start.
        b_obs = obs.size(); b_done = done_cnt;
        pulse_start(); tick(2);
        req = 1'b1; stop = 1'b1; tick(1); req = 1'b0; stop = 1'b0;
        chk("stopreq busy", 32'(busy), 32'd0);
        chk("stopreq addr", 32'(sram_addr), 32'd0);
        tick(3);
        chk("stopreq none", 32'(obs.size() - b_obs), 32'd0);
        chk("stopreq done", 32'(done_cnt - b_done), 32'd0);
        pulse_start(); tick(1);
        pulse_req(); tick(3);
        chk("replay count", 32'(obs.size() - b_obs), 32'd1);
        if (obs.size() > b_obs) chk("replay sample", 32'(obs[b_obs]), 32'h1000);

        // Reset while the pacer sits in FETCH.
        pulse_req();
        rst_n = 1'b0; #1;
        chk("frst addr", 32'(sram_addr), 32'd0);
        chk("frst data", 32'(data), 32'd0);
        chk("frst valid", 32'(valid), 32'd0);
        chk("frst busy", 32'(busy), 32'd0);
        chk("frst done", 32'(done), 32'd0);
        chk("frst pause", 32'(pause_o), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
